// File: rtl/sal4_control_unit.sv
// Salamander-4 multi-cycle sequencer: FETCH/DECODE/EXEC/WB control, PC ownership,
// fetch handshake with timeout fault, halt and illegal-op reporting.
module sal4_control_unit #(
  parameter int PC_WIDTH      = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                INSTR_VALID,
  input  logic [3:0]          OP_CODE,
  input  logic [3:0]          MEM_OP,
  input  logic [7:0]          OPERAND,
  input  logic [3:0]          LEFT_OPERAND,
  input  logic [3:0]          RIGHT_OPERAND,
  input  logic                ZERO,
  output logic [PC_WIDTH-1:0] PC,
  output logic                IMEM_RE,
  output logic                IR_LOAD,
  output logic                ID_CE,
  output logic                ALU_CE,
  output logic                ACC_CE,
  output logic [1:0]          ACC_SRC,
  output logic                REG_WE,
  output logic [3:0]          REG_WADDR,
  output logic [3:0]          REG_RADDR,
  output logic                BUSY,
  output logic                HALTED,
  output logic                FAULT,
  output logic                ILLEGAL
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                fault_q, fault_d;
  logic [3:0]          raddr_q, raddr_d;

  logic                known_op;
  logic                alu_like;
  logic [PC_WIDTH-1:0] jmp_tgt;
  logic [PC_WIDTH-1:0] pc_inc;

  assign known_op = (MEM_OP <= 4'h5) || (MEM_OP == 4'hF);
  // Unknown memory ops fall back to plain ALU behaviour in WB.
  assign alu_like = (MEM_OP == 4'h0) || !known_op;
  assign jmp_tgt  = PC_WIDTH'(OPERAND);
  assign pc_inc   = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (INSTR_VALID) begin
          tmo_d   = '0;
          state_d = S_DECODE;
        end else if (tmo_q + 8'd1 == 8'(FETCH_TIMEOUT)) begin
          tmo_d   = '0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        raddr_d = RIGHT_OPERAND;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
        case (MEM_OP)
          4'h4:    pc_d = jmp_tgt;
          4'h5:    pc_d = ZERO ? jmp_tgt : pc_inc;
          4'hF:    state_d = S_HALT;
          default: pc_d = pc_inc;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
      raddr_q <= raddr_d;
    end
  end

  // Strobes are qualified by the current state so none can leak into another phase.
  assign PC        = pc_q;
  assign IMEM_RE   = (state_q == S_FETCH);
  assign IR_LOAD   = (state_q == S_FETCH) && INSTR_VALID;
  assign ID_CE     = (state_q == S_DECODE);
  assign ALU_CE    = (state_q == S_EXEC) && (OP_CODE != 4'h0);
  assign ILLEGAL   = (state_q == S_EXEC) && !known_op;
  assign ACC_CE    = (state_q == S_WB) &&
                     ((MEM_OP == 4'h1) || (MEM_OP == 4'h2) || (alu_like && (OP_CODE != 4'h0)));
  assign ACC_SRC   = ((state_q == S_WB) && (MEM_OP == 4'h1)) ? 2'd1 :
                     ((state_q == S_WB) && (MEM_OP == 4'h2)) ? 2'd2 : 2'd0;
  assign REG_WE    = (state_q == S_WB) && (MEM_OP == 4'h3);
  assign REG_WADDR = REG_WE ? LEFT_OPERAND : 4'h0;
  assign REG_RADDR = (state_q == S_EXEC) ? RIGHT_OPERAND :
                     (state_q == S_WB)   ? raddr_q : 4'h0;
  assign BUSY      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_WB);
  assign HALTED    = (state_q == S_HALT);
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_sal4_control_unit.sv
// Self-checking bench for sal4_control_unit: instruction-level reference model
// predicts per-phase strobes and the next PC for directed and random programs.
module tb_sal4_control_unit;
  logic       CLK = 1'b0;
  logic       RST, START, INSTR_VALID, ZERO;
  logic [3:0] OP_CODE, MEM_OP, LEFT_OPERAND, RIGHT_OPERAND;
  logic [7:0] OPERAND;
  logic [7:0] PC;
  logic       IMEM_RE, IR_LOAD, ID_CE, ALU_CE, ACC_CE, REG_WE, BUSY, HALTED, FAULT, ILLEGAL;
  logic [1:0] ACC_SRC;
  logic [3:0] REG_WADDR, REG_RADDR;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;

  sal4_control_unit #(.PC_WIDTH(8), .FETCH_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .START(START), .INSTR_VALID(INSTR_VALID),
    .OP_CODE(OP_CODE), .MEM_OP(MEM_OP), .OPERAND(OPERAND),
    .LEFT_OPERAND(LEFT_OPERAND), .RIGHT_OPERAND(RIGHT_OPERAND), .ZERO(ZERO),
    .PC(PC), .IMEM_RE(IMEM_RE), .IR_LOAD(IR_LOAD), .ID_CE(ID_CE), .ALU_CE(ALU_CE),
    .ACC_CE(ACC_CE), .ACC_SRC(ACC_SRC), .REG_WE(REG_WE), .REG_WADDR(REG_WADDR),
    .REG_RADDR(REG_RADDR), .BUSY(BUSY), .HALTED(HALTED), .FAULT(FAULT), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // {IMEM_RE, IR_LOAD, ID_CE, ALU_CE, ACC_CE, REG_WE, ILLEGAL, BUSY, HALTED, FAULT}
  wire [9:0] obs = {IMEM_RE, IR_LOAD, ID_CE, ALU_CE, ACC_CE, REG_WE, ILLEGAL, BUSY, HALTED, FAULT};

  // Instruction-level model: what one instruction should do in writeback and where PC goes next.
  function automatic void model(input logic [3:0] op, input logic [3:0] mem, input logic [7:0] opnd,
                                input logic z, input int pc,
                                output logic acc, output logic we, output logic ill,
                                output logic [1:0] src, output logic [3:0] waddr,
                                output int npc, output logic halt);
    ill = !(mem <= 4'h5 || mem == 4'hF);
    acc = 1'b0; we = 1'b0; src = 2'd0; waddr = 4'h0; halt = 1'b0;
    npc = (pc + 1) % 256;
    case (mem)
      4'h1: begin acc = 1'b1; src = 2'd1; end
      4'h2: begin acc = 1'b1; src = 2'd2; end
      4'h3: begin we = 1'b1; waddr = opnd[7:4]; end
      4'h4: npc = opnd;
      4'h5: npc = z ? int'(opnd) : (pc + 1) % 256;
      4'hF: begin npc = pc; halt = 1'b1; end
      default: acc = (op != 4'h0);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1; START = 1'b0; INSTR_VALID = 1'b0;
    @(negedge CLK); RST = 1'b0;
    model_pc = 0;
  endtask

  // Leaves the DUT one cycle before its first FETCH.
  task automatic start_prog();
    @(negedge CLK); RST = 1'b0; START = 1'b1; #1;
    checks++;
    if (obs !== 10'b0 || PC !== 8'h00) begin
      errors++; $display("FAIL start_idle obs=%b pc=%h required obs=0 pc=00", obs, PC);
    end
  endtask

  // Runs one instruction starting from the cycle before its FETCH.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] mem, input logic [7:0] opnd,
                           input logic z, input int stalls);
    logic acc, we, ill, halt; logic [1:0] src; logic [3:0] waddr; int npc;
    model(op, mem, opnd, z, model_pc, acc, we, ill, src, waddr, npc, halt);
    for (int i = 0; i < stalls; i++) begin
      @(negedge CLK); START = 1'($urandom); INSTR_VALID = 1'b0; #1;
      checks++;
      if (obs !== 10'b10_0000_0100) begin
        errors++; $display("FAIL fetch_wait%0d obs=%b required %b", i, obs, 10'b10_0000_0100);
      end
    end
    @(negedge CLK); START = 1'($urandom); INSTR_VALID = 1'b1; #1;
    checks++;
    if (obs !== 10'b11_0000_0100 || PC !== 8'(model_pc)) begin
      errors++; $display("FAIL fetch obs=%b pc=%h required obs=%b pc=%h", obs, PC, 10'b11_0000_0100, 8'(model_pc));
    end
    @(negedge CLK); START = 1'($urandom); INSTR_VALID = 1'($urandom);
    OP_CODE = op; MEM_OP = mem; OPERAND = opnd; LEFT_OPERAND = opnd[7:4]; RIGHT_OPERAND = opnd[3:0]; ZERO = z; #1;
    checks++;
    if (obs !== 10'b00_1000_0100) begin
      errors++; $display("FAIL decode obs=%b required %b", obs, 10'b00_1000_0100);
    end
    @(negedge CLK); START = 1'($urandom); INSTR_VALID = 1'($urandom); #1;
    checks++;
    if (obs !== {3'b000, op != 4'h0, 2'b00, ill, 3'b100} || REG_RADDR !== opnd[3:0]) begin
      errors++; $display("FAIL exec obs=%b raddr=%h required obs=%b raddr=%h",
                         obs, REG_RADDR, {3'b000, op != 4'h0, 2'b00, ill, 3'b100}, opnd[3:0]);
    end
    @(negedge CLK); START = 1'($urandom); INSTR_VALID = 1'($urandom); #1;
    checks++;
    if (obs !== {4'b0000, acc, we, 4'b0100} || ACC_SRC !== src || REG_WADDR !== waddr ||
        REG_RADDR !== opnd[3:0]) begin
      errors++; $display("FAIL wb mem=%h obs=%b src=%0d waddr=%h raddr=%h required obs=%b src=%0d waddr=%h raddr=%h",
                         mem, obs, ACC_SRC, REG_WADDR, REG_RADDR, {4'b0000, acc, we, 4'b0100}, src, waddr, opnd[3:0]);
    end
    model_pc = npc;
    if (halt) begin
      @(negedge CLK); #1;
      checks++;
      if (obs !== 10'b00_0000_0010 || PC !== 8'(model_pc)) begin
        errors++; $display("FAIL halt_entry obs=%b pc=%h required obs=%b pc=%h", obs, PC, 10'b00_0000_0010, 8'(model_pc));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK); RST = 1'b1; START = 1'b1; INSTR_VALID = 1'b1;
    OP_CODE = 4'h0; MEM_OP = 4'h0; OPERAND = 8'h00; LEFT_OPERAND = 4'h0; RIGHT_OPERAND = 4'h0; ZERO = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (obs !== 10'b0 || PC !== 8'h00 || ACC_SRC !== 2'd0 || REG_WADDR !== 4'h0 || REG_RADDR !== 4'h0) begin
      errors++; $display("FAIL reset obs=%b pc=%h required all zero", obs, PC);
    end
    model_pc = 0;
  endtask

  task automatic test_straight_line();
    start_prog();
    for (int i = 0; i < 3; i++) run_instr(4'h2, 4'h0, 8'h00, 1'b0, 0);
    @(negedge CLK); START = 1'b0; INSTR_VALID = 1'b0; #1;
    checks++;
    if (PC !== 8'h03 || IMEM_RE !== 1'b1) begin
      errors++; $display("FAIL straight_pc pc=%h re=%b required pc=03 re=1", PC, IMEM_RE);
    end
    do_reset();
  endtask

  task automatic test_mem_ops();
    start_prog();
    run_instr(4'h0, 4'h1, 8'h5A, 1'b0, 0);
    run_instr(4'h0, 4'h3, 8'h73, 1'b0, 1);
    run_instr(4'h0, 4'h2, 8'h09, 1'b0, 0);
    run_instr(4'h0, 4'h0, 8'h11, 1'b0, 0);  // NOP: no ALU, no accumulator write
    run_instr(4'h5, 4'h9, 8'h22, 1'b1, 0);  // illegal op behaves as ALU-only
    do_reset();
  endtask

  task automatic test_branching();
    start_prog();
    run_instr(4'h0, 4'h4, 8'h40, 1'b1, 0);
    run_instr(4'h0, 4'h5, 8'h10, 1'b0, 0);
    run_instr(4'h0, 4'h5, 8'h10, 1'b1, 0);
    run_instr(4'h0, 4'h4, 8'hFF, 1'b0, 0);
    run_instr(4'h3, 4'h0, 8'h00, 1'b0, 0);
    run_instr(4'h1, 4'h0, 8'h00, 1'b0, 0);  // its FETCH checks the wrapped PC=0
    do_reset();
  endtask

  task automatic test_stall_timeout();
    start_prog();
    run_instr(4'h2, 4'h0, 8'h00, 1'b0, 3);
    run_instr(4'h2, 4'h0, 8'h00, 1'b0, 14);  // valid on the last allowed cycle
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK); INSTR_VALID = 1'b0; START = 1'b0; #1;
      checks++;
      if (obs !== 10'b10_0000_0100) begin
        errors++; $display("FAIL timeout_wait%0d obs=%b required %b", i, obs, 10'b10_0000_0100);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); START = 1'b1; INSTR_VALID = 1'b1; #1;
      checks++;
      if (obs !== 10'b00_0000_0011 || PC !== 8'(model_pc)) begin
        errors++; $display("FAIL timeout_halt%0d obs=%b pc=%h required obs=%b pc=%h", i, obs, PC, 10'b00_0000_0011, 8'(model_pc));
      end
    end
    @(negedge CLK); RST = 1'b1; START = 1'b0;
    @(negedge CLK); RST = 1'b0; #1;
    checks++;
    if (obs !== 10'b0 || PC !== 8'h00) begin
      errors++; $display("FAIL timeout_clear obs=%b pc=%h required obs=0 pc=00", obs, PC);
    end
    model_pc = 0;
  endtask

  task automatic test_halt_and_midreset();
    start_prog();
    run_instr(4'h0, 4'h4, 8'h37, 1'b0, 0);
    run_instr(4'h6, 4'hF, 8'h00, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); START = 1'b1; INSTR_VALID = 1'b1; #1;
      checks++;
      if (obs !== 10'b00_0000_0010 || PC !== 8'h37) begin
        errors++; $display("FAIL halt_hold%0d obs=%b pc=%h required obs=%b pc=37", i, obs, PC, 10'b00_0000_0010);
      end
    end
    do_reset();
    start_prog();
    run_instr(4'h0, 4'h4, 8'h22, 1'b0, 0);
    @(negedge CLK); START = 1'b0; INSTR_VALID = 1'b1;
    @(negedge CLK); INSTR_VALID = 1'b0; OP_CODE = 4'h3; MEM_OP = 4'h3; OPERAND = 8'h51;
    LEFT_OPERAND = 4'h5; RIGHT_OPERAND = 4'h1;
    @(negedge CLK); RST = 1'b1; #1;
    checks++;
    if (ALU_CE !== 1'b1 || PC !== 8'h22) begin
      errors++; $display("FAIL midreset_exec alu_ce=%b pc=%h required alu_ce=1 pc=22", ALU_CE, PC);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); RST = 1'b0; #1;
      checks++;
      if (obs !== 10'b0 || PC !== 8'h00) begin
        errors++; $display("FAIL midreset_idle%0d obs=%b pc=%h required obs=0 pc=00", i, obs, PC);
      end
    end
    model_pc = 0;
  endtask

  task automatic test_random();
    logic [3:0] mem;
    start_prog();
    for (int n = 0; n < 40; n++) begin
      mem = 4'($urandom_range(0, 14));
      run_instr(4'($urandom), mem, 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    do_reset();
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; INSTR_VALID = 1'b0; ZERO = 1'b0;
    OP_CODE = 4'h0; MEM_OP = 4'h0; OPERAND = 8'h00; LEFT_OPERAND = 4'h0; RIGHT_OPERAND = 4'h0;
    test_reset();
    test_straight_line();
    test_mem_ops();
    test_branching();
    test_stall_timeout();
    test_halt_and_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
